counter_en_ctrl: RTL and testbench

COUNTER_EN_CTRL -- requirements
Module: counter_en_ctrl

---
 rtl/counter_en_ctrl_pkg.sv | 14 +
 rtl/counter_en_ctrl_tick_prescaler.sv | 33 +++
 rtl/counter_en_ctrl.sv | 123 ++++++++++++
 tb/tb_counter_en_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_en_ctrl_pkg.sv
// rtl/counter_en_ctrl_pkg.sv - shared types and default widths for counter_en_ctrl
// Contents: FSM state type and default parameter values for the prescaler and burst counter.
package counter_en_ctrl_pkg;

  localparam int DIV_W_DEF   = 8;
  localparam int BURST_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

endpackage

// File: rtl/counter_en_ctrl_tick_prescaler.sv
// rtl/counter_en_ctrl_tick_prescaler.sv - loadable down-counter with terminal flag and auto-reload
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   load, load_val  load load_val immediately (takes priority over en)
//   en, reload_val  count down while en; on reaching zero reload reload_val
//   tc              terminal flag, high while the count is zero
module tick_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] reload_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= tc ? reload_val : cnt - W'(1);
    end
  end

endmodule

// File: rtl/counter_en_ctrl.sv
// rtl/counter_en_ctrl.sv - enable-pulse generator for a downstream counter (continuous, burst, single step)
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   start, stop, step  commands, priority stop > start > step
//   mode               0 = continuous, 1 = burst
//   div                tick period minus one
//   burst_len          pulses per burst, 0 means 2^BURST_W
//   enable             registered one-cycle enable pulse
//   busy               high while not IDLE
//   done               registered one-cycle completion pulse
//   pulse_cnt          enables issued in the current run (wraps)
module counter_en_ctrl
  import counter_en_ctrl_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic               mode,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_cnt
);

  state_t             state, state_nxt;
  logic               enable_nxt, done_nxt;
  logic               latch, inc_cnt, pre_en, pre_tc;
  logic               burst_end;
  logic [DIV_W-1:0]   div_q;
  logic               mode_q;
  logic [BURST_W-1:0] burst_len_q;

  assign busy = (state != ST_IDLE);

  // The enable currently on the output is the last of the burst when the
  // count it produced equals burst_len; burst_len=0 matches on the wrap to 0.
  assign burst_end = enable && mode_q && (pulse_cnt == burst_len_q);

  tick_prescaler #(.W(DIV_W)) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .load      (latch),
    .load_val  (div),
    .en        (pre_en),
    .reload_val(div_q),
    .tc        (pre_tc)
  );

  always_comb begin
    state_nxt  = state;
    enable_nxt = 1'b0;
    done_nxt   = 1'b0;
    latch      = 1'b0;
    inc_cnt    = 1'b0;
    pre_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (start) begin
          state_nxt = ST_RUN;
          latch     = 1'b1;
        end else if (step) begin
          // enable is raised on entry so it is high for the whole STEP cycle
          state_nxt  = ST_STEP;
          enable_nxt = 1'b1;
          inc_cnt    = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (burst_end) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          pre_en = 1'b1;
          if (pre_tc) begin
            enable_nxt = 1'b1;
            inc_cnt    = 1'b1;
          end
        end
      end
      ST_STEP: begin
        state_nxt = ST_IDLE;
        done_nxt  = !stop;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      enable      <= 1'b0;
      done        <= 1'b0;
      pulse_cnt   <= '0;
      div_q       <= '0;
      mode_q      <= 1'b0;
      burst_len_q <= '0;
    end else begin
      state  <= state_nxt;
      enable <= enable_nxt;
      done   <= done_nxt;
      if (latch) begin
        div_q       <= div;
        mode_q      <= mode;
        burst_len_q <= burst_len;
        pulse_cnt   <= '0;
      end else if (inc_cnt) begin
        pulse_cnt <= pulse_cnt + BURST_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter_en_ctrl.sv
// tb/tb_counter_en_ctrl.sv - scoreboard testbench for counter_en_ctrl
module tb_counter_en_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] div = '0;
  logic [3:0] burst_len = '0;
  logic       enable, busy, done;
  logic [3:0] pulse_cnt;

  counter_en_ctrl #(.DIV_W(8), .BURST_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .step     (step),
    .mode     (mode),
    .div      (div),
    .burst_len(burst_len),
    .enable   (enable),
    .busy     (busy),
    .done     (done),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit       is_done;
    int       cyc;
    bit [3:0] cnt;
  } ev_t;

  ev_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [3:0] ds_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input bit is_done, input int c, input int cnt);
    ev_t ev;
    ev.is_done = is_done;
    ev.cyc     = c;
    ev.cnt     = cnt[3:0];
    sb.push_back(ev);
  endtask

  // Monitor: every enable/done pulse must match the next expected event.
  always @(negedge clk) begin
    ev_t ev;
    if (enable) ds_cnt = ds_cnt + 4'd1;
    if (enable || done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output cyc=%0d actual enable=%b done=%b expected none", cyc, enable, done);
      end else begin
        ev = sb.pop_front();
        check("ev_kind_done", {31'd0, done}, {31'd0, ev.is_done});
        check("ev_enable_done_excl", {31'd0, enable & done}, 32'd0);
        check("ev_cycle", cyc, ev.cyc);
        check("ev_pulse_cnt", {28'd0, pulse_cnt}, {28'd0, ev.cnt});
        check("ev_busy", {31'd0, busy}, {31'd0, !ev.is_done});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_start(input int d, input bit m, input int l, output int e);
    div       = d[7:0];
    mode      = m;
    burst_len = l[3:0];
    start     = 1'b1;
    e         = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int e;
    rst = 1'b0;
    repeat (3) tick();
    check("reset_enable", {31'd0, enable}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_pulse_cnt", {28'd0, pulse_cnt}, 32'd0);
    rst = 1'b1;
    tick();

    // continuous div=2; busy-time command and config changes must be ignored
    do_start(2, 1'b0, 0, e);
    push(0, e + 3, 1); push(0, e + 6, 2); push(0, e + 9, 3);
    div = 8'd0; mode = 1'b1; burst_len = 4'd1; start = 1'b1; step = 1'b1;
    tick();
    start = 1'b0; step = 1'b0;
    wait_cyc(e + 10);
    check("cont_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("cont_stop_idle", {31'd0, busy}, 32'd0);
    check("cont_pulse_cnt", {28'd0, pulse_cnt}, 32'd3);

    // stop in IDLE, then start+stop together: both leave IDLE untouched
    stop = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    check("start_stop_idle", {31'd0, busy}, 32'd0);
    check("start_stop_cnt_kept", {28'd0, pulse_cnt}, 32'd3);

    // continuous div=3, stop sampled on the prescaler-zero edge
    do_start(3, 1'b0, 0, e);
    push(0, e + 4, 1);
    wait_cyc(e + 7);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_tc_idle", {31'd0, busy}, 32'd0);
    check("stop_tc_pulse_cnt", {28'd0, pulse_cnt}, 32'd1);
    repeat (5) tick();

    // burst div=0 len=5
    do_start(0, 1'b1, 5, e);
    for (int k = 1; k <= 5; k++) push(0, e + k, k);
    push(1, e + 6, 5);
    wait_cyc(e + 8);
    check("burst5_busy", {31'd0, busy}, 32'd0);
    check("burst5_pulse_cnt", {28'd0, pulse_cnt}, 32'd5);

    // burst len=0 -> 16 pulses, wraps to 0
    ds_cnt = 4'd0;
    do_start(0, 1'b1, 0, e);
    for (int k = 1; k <= 16; k++) push(0, e + k, k % 16);
    push(1, e + 17, 0);
    wait_cyc(e + 19);
    check("burst16_pulse_cnt", {28'd0, pulse_cnt}, 32'd0);
    check("burst16_downstream", {28'd0, ds_cnt}, 32'd0);
    check("burst16_busy", {31'd0, busy}, 32'd0);

    // single step; step held into the STEP cycle is ignored
    e = cyc + 1;
    push(0, e, 1); push(1, e + 1, 1);
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    wait_cyc(e + 5);
    check("step_pulse_cnt", {28'd0, pulse_cnt}, 32'd1);
    check("step_busy", {31'd0, busy}, 32'd0);

    // reset mid-burst after 3 pulses
    do_start(1, 1'b1, 8, e);
    push(0, e + 2, 1); push(0, e + 4, 2); push(0, e + 6, 3);
    wait_cyc(e + 6);
    rst = 1'b0;
    tick();
    check("midrst_enable", {31'd0, enable}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_pulse_cnt", {28'd0, pulse_cnt}, 32'd0);
    repeat (8) tick();
    rst = 1'b1;
    tick();

    // fresh start after reset
    do_start(2, 1'b0, 0, e);
    push(0, e + 3, 1); push(0, e + 6, 2); push(0, e + 9, 3);
    wait_cyc(e + 10);
    check("post_rst_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
